// File: rtl/dmem_wbuf.sv
// dmem_wbuf: single-port data RAM with an in-order posted-write buffer and load forwarding
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   addr, wdata, we, re CPU word address, store data, store strobe, load strobe
//   rdata, rvalid       registered load data and its one-cycle valid pulse
//   busy                a RAM-miss load was deferred and has not returned yet
//   dbg_req, dbg_addr   debug read request (held until dbg_ack) and address
//   dbg_data, dbg_ack   registered debug read data and its one-cycle pulse
//   wb_count            occupied posted-write entries
//   ovf, rdrop          sticky flags: a store was dropped / a load was dropped
module dmem_wbuf #(
    parameter int ADDR_W   = 8,
    parameter int WB_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic              we,
    input  logic              re,
    output logic [31:0]       rdata,
    output logic              rvalid,
    output logic              busy,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [31:0]       dbg_data,
    output logic              dbg_ack,
    output logic [2:0]        wb_count,
    output logic              ovf,
    output logic              rdrop
);
    localparam int PW = WB_DEPTH > 1 ? $clog2(WB_DEPTH) : 1;

    logic [31:0]       mem [2**ADDR_W];
    logic [ADDR_W-1:0] fa_q [WB_DEPTH];
    logic [31:0]       fd_q [WB_DEPTH];
    logic [PW-1:0]     wptr_q, rptr_q, wptr_d, rptr_d, fidx;
    logic [2:0]        cnt_q, cnt_d;
    logic              pend_q;
    logic [ADDR_W-1:0] pend_addr_q;
    logic [31:0]       rdata_q, dbg_data_q;
    logic              rvalid_q, dbg_ack_q, ovf_q, rdrop_q;
    logic              ld_hit, dbg_hit;
    logic [31:0]       ld_fd, dbg_fd, ram_rd;
    logic [ADDR_W-1:0] rd_addr;
    logic              full, ld_miss, defer, ld_ram, dbg_go, dbg_ram, pop, push, drop_st;

    // Walk valid entries oldest to newest so the newest match wins.
    always_comb begin
        ld_hit  = 1'b0;
        ld_fd   = '0;
        dbg_hit = 1'b0;
        dbg_fd  = '0;
        fidx    = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            fidx = PW'((int'(rptr_q) + i) % WB_DEPTH);
            if (i < int'(cnt_q) && fa_q[fidx] == addr) begin
                ld_hit = 1'b1;
                ld_fd  = fd_q[fidx];
            end
            if (i < int'(cnt_q) && fa_q[fidx] == dbg_addr) begin
                dbg_hit = 1'b1;
                dbg_fd  = fd_q[fidx];
            end
        end
    end

    // A forced drain only ever races a new load, and the deferred load missed
    // the buffer, so reading RAM one cycle later still returns its snapshot.
    always_comb begin
        full    = cnt_q == 3'(WB_DEPTH);
        ld_miss = re & ~pend_q & ~ld_hit;
        defer   = ld_miss & full;
        ld_ram  = ld_miss & ~full;
        dbg_go  = dbg_req & ~dbg_ack_q & ~pend_q & ~full & ~re;
        dbg_ram = dbg_go & ~dbg_hit;
        pop     = cnt_q != 3'd0 & ~pend_q & ~ld_ram & ~dbg_ram;
        push    = we & (~full | pop);
        drop_st = we & full & ~pop;
        rd_addr = pend_q ? pend_addr_q : ld_ram ? addr : dbg_addr;
        ram_rd  = mem[rd_addr];
        wptr_d  = push ? (wptr_q == PW'(WB_DEPTH - 1) ? '0 : wptr_q + PW'(1)) : wptr_q;
        rptr_d  = pop ? (rptr_q == PW'(WB_DEPTH - 1) ? '0 : rptr_q + PW'(1)) : rptr_q;
        cnt_d   = push & ~pop ? cnt_q + 3'd1 : pop & ~push ? cnt_q - 3'd1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fa_q[wptr_q] <= addr;
            fd_q[wptr_q] <= wdata;
        end
        if (pop) mem[fa_q[rptr_q]] <= fd_q[rptr_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            dbg_data_q  <= '0;
            dbg_ack_q   <= 1'b0;
            ovf_q       <= 1'b0;
            rdrop_q     <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            pend_q    <= defer;
            rvalid_q  <= pend_q | (re & ~defer);
            dbg_ack_q <= dbg_go;
            ovf_q     <= ovf_q | drop_st;
            rdrop_q   <= rdrop_q | (re & pend_q);
            if (defer) pend_addr_q <= addr;
            if (pend_q | ld_ram) rdata_q <= ram_rd;
            else if (re) rdata_q <= ld_fd;
            if (dbg_go) dbg_data_q <= dbg_hit ? dbg_fd : ram_rd;
        end
    end

    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign busy     = pend_q;
    assign dbg_data = dbg_data_q;
    assign dbg_ack  = dbg_ack_q;
    assign wb_count = cnt_q;
    assign ovf      = ovf_q;
    assign rdrop    = rdrop_q;
endmodule

// File: tb/tb_dmem_wbuf.sv
// tb_dmem_wbuf: directed checks of posting, forwarding, arbitration, deferral and reset
module tb_dmem_wbuf;
    logic        clk = 1'b0, rst = 1'b1;
    logic [7:0]  addr = '0, dbg_addr = '0;
    logic [31:0] wdata = '0;
    logic        we = 1'b0, re = 1'b0, dbg_req = 1'b0;
    logic [31:0] rdata, dbg_data;
    logic        rvalid, busy, dbg_ack, ovf, rdrop;
    logic [2:0]  wb_count;
    int          nvec = 0, nerr = 0;

    dmem_wbuf #(.ADDR_W(8), .WB_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .rdata(rdata), .rvalid(rvalid), .busy(busy), .dbg_req(dbg_req),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_ack(dbg_ack),
        .wb_count(wb_count), .ovf(ovf), .rdrop(rdrop)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        nvec++; if (rvalid !== 1'b0) begin nerr++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", busy); end
        nvec++; if (wb_count !== 3'd0) begin nerr++; $display("FAIL reset_count: got %0d want 0", wb_count); end
        nvec++; if ({ovf, rdrop, dbg_ack} !== 3'b000) begin nerr++; $display("FAIL reset_flags: got %b want 000", {ovf, rdrop, dbg_ack}); end
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_preload();
        logic [7:0]  a [4] = '{8'd3, 8'd7, 8'd9, 8'd12};
        logic [31:0] d [4] = '{32'h33, 32'h77, 32'h99, 32'hC0C0};
        for (int i = 0; i < 4; i++) begin
            we = 1'b1; addr = a[i]; wdata = d[i];
            cyc();
            nvec++; if (wb_count !== 3'd1) begin nerr++; $display("FAIL preload_count%0d: got %0d want 1", i, wb_count); end
        end
        we = 1'b0;
        cyc();
        cyc();
        nvec++; if (wb_count !== 3'd0) begin nerr++; $display("FAIL preload_drained: got %0d want 0", wb_count); end
    endtask

    task automatic test_forward();
        we = 1'b1; addr = 8'd5; wdata = 32'hDEADBEEF;
        cyc();
        nvec++; if (wb_count !== 3'd1) begin nerr++; $display("FAIL fwd_count1: got %0d want 1", wb_count); end
        we = 1'b0; re = 1'b1;
        cyc();
        nvec++; if (rvalid !== 1'b1) begin nerr++; $display("FAIL fwd_rvalid: got %b want 1", rvalid); end
        nvec++; if (rdata !== 32'hDEADBEEF) begin nerr++; $display("FAIL fwd_rdata: got %h want deadbeef", rdata); end
        nvec++; if (wb_count !== 3'd0) begin nerr++; $display("FAIL fwd_drained: got %0d want 0", wb_count); end
        re = 1'b0;
        cyc();
        nvec++; if (rvalid !== 1'b0) begin nerr++; $display("FAIL fwd_rvalid_pulse: got %b want 0", rvalid); end
        re = 1'b1; addr = 8'd5;
        cyc();
        nvec++; if (rdata !== 32'hDEADBEEF) begin nerr++; $display("FAIL ram_rdata5: got %h want deadbeef", rdata); end
        addr = 8'd9;
        cyc();
        nvec++; if (rdata !== 32'h99) begin nerr++; $display("FAIL ram_rdata9: got %h want 99", rdata); end
        re = 1'b0;
        cyc();
    endtask

    task automatic test_newest();
        we = 1'b1; re = 1'b1; addr = 8'd7; wdata = 32'd1;
        cyc();
        nvec++; if (rdata !== 32'h77) begin nerr++; $display("FAIL same_cycle_store_hidden: got %h want 77", rdata); end
        re = 1'b0; wdata = 32'd2; dbg_req = 1'b1; dbg_addr = 8'd3;
        cyc();
        nvec++; if (wb_count !== 3'd2) begin nerr++; $display("FAIL newest_count2: got %0d want 2", wb_count); end
        nvec++; if (dbg_ack !== 1'b1 || dbg_data !== 32'h33) begin nerr++; $display("FAIL newest_dbg: got ack %b data %h want 1/33", dbg_ack, dbg_data); end
        we = 1'b0; dbg_req = 1'b0; re = 1'b1;
        cyc();
        nvec++; if (rvalid !== 1'b1 || rdata !== 32'd2) begin nerr++; $display("FAIL newest_wins: got %b/%h want 1/2", rvalid, rdata); end
        nvec++; if (wb_count !== 3'd1 || dbg_ack !== 1'b0) begin nerr++; $display("FAIL newest_after: got count %0d ack %b want 1/0", wb_count, dbg_ack); end
        re = 1'b0;
        cyc();
        cyc();
        re = 1'b1;
        cyc();
        nvec++; if (rdata !== 32'd2 || wb_count !== 3'd0) begin nerr++; $display("FAIL newest_ram7: got %h count %0d want 2/0", rdata, wb_count); end
        re = 1'b0;
        cyc();
    endtask

    task automatic test_forced_drain();
        for (int i = 0; i < 4; i++) begin
            we = 1'b1; re = 1'b1; addr = 8'(20 + i); wdata = 32'hA0 + i;
            cyc();
        end
        nvec++; if (wb_count !== 3'd4) begin nerr++; $display("FAIL fill_count: got %0d want 4", wb_count); end
        addr = 8'd9; wdata = 32'h1234;
        cyc();
        nvec++; if (busy !== 1'b1 || rvalid !== 1'b0) begin nerr++; $display("FAIL defer: got busy %b rvalid %b want 1/0", busy, rvalid); end
        nvec++; if (wb_count !== 3'd4 || ovf !== 1'b0) begin nerr++; $display("FAIL defer_count: got %0d ovf %b want 4/0", wb_count, ovf); end
        addr = 8'd30; wdata = 32'hBAD;
        cyc();
        nvec++; if (rvalid !== 1'b1 || rdata !== 32'h99) begin nerr++; $display("FAIL deferred_data: got %b/%h want 1/99", rvalid, rdata); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL busy_clear: got %b want 0", busy); end
        nvec++; if (ovf !== 1'b1 || rdrop !== 1'b1) begin nerr++; $display("FAIL drop_flags: got ovf %b rdrop %b want 1/1", ovf, rdrop); end
        nvec++; if (wb_count !== 3'd4) begin nerr++; $display("FAIL drop_count: got %0d want 4", wb_count); end
        we = 1'b0; re = 1'b0;
        cyc();
        nvec++; if (rvalid !== 1'b0 || wb_count !== 3'd3) begin nerr++; $display("FAIL dropped_load: got rvalid %b count %0d want 0/3", rvalid, wb_count); end
        cyc(); cyc(); cyc();
        re = 1'b1; addr = 8'd9;
        cyc();
        nvec++; if (rdata !== 32'h1234 || wb_count !== 3'd0) begin nerr++; $display("FAIL drained9: got %h count %0d want 1234/0", rdata, wb_count); end
        re = 1'b0;
        cyc();
    endtask

    task automatic test_debug();
        re = 1'b1; addr = 8'd12; dbg_req = 1'b1; dbg_addr = 8'd3;
        for (int i = 0; i < 3; i++) begin
            cyc();
            nvec++; if (dbg_ack !== 1'b0 || rdata !== 32'hC0C0) begin nerr++; $display("FAIL dbg_blocked%0d: got ack %b rdata %h want 0/c0c0", i, dbg_ack, rdata); end
        end
        re = 1'b0;
        cyc();
        nvec++; if (dbg_ack !== 1'b1 || dbg_data !== 32'h33) begin nerr++; $display("FAIL dbg_ram: got %b/%h want 1/33", dbg_ack, dbg_data); end
        dbg_req = 1'b0;
        cyc();
        nvec++; if (dbg_ack !== 1'b0) begin nerr++; $display("FAIL dbg_pulse: got %b want 0", dbg_ack); end
        we = 1'b1; addr = 8'd3; wdata = 32'h3333;
        cyc();
        we = 1'b0; dbg_req = 1'b1;
        cyc();
        nvec++; if (dbg_ack !== 1'b1 || dbg_data !== 32'h3333) begin nerr++; $display("FAIL dbg_fwd: got %b/%h want 1/3333", dbg_ack, dbg_data); end
        nvec++; if (ovf !== 1'b1 || rdrop !== 1'b1) begin nerr++; $display("FAIL sticky: got ovf %b rdrop %b want 1/1", ovf, rdrop); end
        dbg_req = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid();
        logic [7:0] a [4] = '{8'd40, 8'd12, 8'd41, 8'd42};
        for (int i = 0; i < 4; i++) begin
            we = 1'b1; re = 1'b1; addr = a[i]; wdata = 32'hBADBAD;
            cyc();
        end
        we = 1'b0; addr = 8'd9;
        cyc();
        nvec++; if (wb_count !== 3'd3 || busy !== 1'b1) begin nerr++; $display("FAIL pre_rst: got count %0d busy %b want 3/1", wb_count, busy); end
        re = 1'b0;
        #2 rst = 1'b1;
        #1;
        nvec++; if ({rvalid, busy, dbg_ack, ovf, rdrop} !== 5'b0) begin nerr++; $display("FAIL rst_flags: got %b want 00000", {rvalid, busy, dbg_ack, ovf, rdrop}); end
        nvec++; if (wb_count !== 3'd0 || rdata !== 32'd0 || dbg_data !== 32'd0) begin nerr++; $display("FAIL rst_data: got %0d/%h/%h want 0/0/0", wb_count, rdata, dbg_data); end
        cyc();
        rst = 1'b0;
        re = 1'b1; addr = 8'd12;
        cyc();
        nvec++; if (rvalid !== 1'b1 || rdata !== 32'hC0C0) begin nerr++; $display("FAIL post_rst_load: got %b/%h want 1/c0c0", rvalid, rdata); end
        nvec++; if (wb_count !== 3'd0 || busy !== 1'b0) begin nerr++; $display("FAIL post_rst_state: got count %0d busy %b want 0/0", wb_count, busy); end
        re = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_preload();
        test_forward();
        test_newest();
        test_forced_drain();
        test_debug();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
